// File: rtl/i2c_addr_receiver.sv
// i2c_addr_receiver: 7-bit I2C address match with ACK drive.
// Define GENERAL_CALL_EN to also ACK the general call address (0x00, write).
module i2c_addr_receiver #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic scl,
  input  logic sda,
  input  logic start,
  output logic sda_oe,
  output logic addr_match,
  output logic rw,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_DRIVE, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sr, sr_n, sr_sh;
  logic rw_n, scl_q, scl_rise, scl_fall, hit;
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign sr_sh = {sr[6:0], sda};
`ifdef GENERAL_CALL_EN
  assign hit = sr_sh[7:1] == SLAVE_ADDR || sr_sh == 8'h00;
`else
  assign hit = sr_sh[7:1] == SLAVE_ADDR;
`endif
  assign addr_match = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    rw_n = rw;
    if (!enable) state_n = IDLE;
    else if (start) begin
      state_n = SHIFT;
      cnt_n = 4'd0;
      sr_n = 8'd0;
    end else begin
      case (state)
        SHIFT:
          if (scl_rise) begin
            sr_n = sr_sh;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              state_n = hit ? ACK_WAIT : IDLE;
              rw_n = hit ? sr_sh[0] : rw;
            end
          end
        ACK_WAIT: state_n = scl_fall ? ACK_DRIVE : ACK_WAIT;
        ACK_DRIVE: state_n = scl_fall ? DONE : ACK_DRIVE;
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      sr <= 8'd0;
      scl_q <= 1'b1;
      sda_oe <= 1'b0;
      rw <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      scl_q <= scl;
      sda_oe <= state_n == ACK_DRIVE;
      rw <= rw_n;
    end
  end
endmodule
